// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter driving open-drain enables.
//            Optional macro PS2_HOST_TX_RETRY_EN: up to 2 automatic retries.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_active,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

`ifdef PS2_HOST_TX_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_ACK       = 3'd5,
    S_WAIT_IDLE = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic            par_q, par_d;
  logic            ack_q, ack_d;
  logic [1:0]      retry_q, retry_d;
  logic            clk_s1_q, clk_s2_q, clk_prev_q;
  logic            dat_s1_q, dat_s2_q;
  logic            done_q, ack_ok_q, err_q;

  logic fe;
  logic in_frame;
  logic can_retry;
  logic fail;
  logic finish;
  logic finish_ok;

  // Falling edge of the synchronised device clock.
  assign fe        = clk_prev_q & ~clk_s2_q;
  assign in_frame  = (state_q == S_REQ) || (state_q == S_DATA) ||
                     (state_q == S_PARITY) || (state_q == S_ACK);
  assign can_retry = RETRY_EN && (retry_q != 2'd2);

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    par_d     = par_q;
    bit_d     = bit_q;
    ack_d     = ack_q;
    retry_d   = retry_q;
    fail      = 1'b0;
    finish    = 1'b0;
    finish_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_INHIBIT;
          byte_d  = tx_data;
          par_d   = ~^tx_data;
          bit_d   = 3'd0;
          retry_d = 2'd0;
        end
      end
      S_INHIBIT:   if (cnt_q == INH_LAST) state_d = S_REQ;
      S_REQ:       if (fe) state_d = S_DATA;
      S_DATA: begin
        if (fe) begin
          if (bit_q == 3'd7) state_d = S_PARITY;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_PARITY:    if (fe) state_d = S_ACK;
      S_ACK: begin
        if (fe) begin
          state_d = S_WAIT_IDLE;
          ack_d   = ~dat_s2_q;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          if (ack_q) begin
            state_d   = S_DONE;
            finish    = 1'b1;
            finish_ok = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if ((in_frame || state_q == S_WAIT_IDLE) && (state_d == state_q) && (cnt_q == TMO_LAST))
      fail = 1'b1;

    if (fail) begin
      if (can_retry) begin
        state_d = S_INHIBIT;
        retry_d = retry_q + 2'd1;
        bit_d   = 3'd0;
      end else begin
        state_d = S_DONE;
        finish  = 1'b1;
      end
    end

    // One counter times both the inhibit phase and the per-edge timeout.
    if ((state_d != state_q) || (in_frame && fe) || (state_q == S_IDLE) || (state_q == S_DONE))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 8'd0;
      par_q      <= 1'b0;
      ack_q      <= 1'b0;
      retry_q    <= 2'd0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      ack_q      <= ack_d;
      retry_q    <= retry_d;
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_i;
      dat_s2_q   <= dat_s1_q;
      done_q     <= finish;
      ack_ok_q   <= finish & finish_ok;
      err_q      <= finish & ~finish_ok;
    end
  end

  always_comb begin
    ps2_data_oe = 1'b0;
    case (state_q)
      S_INHIBIT: ps2_data_oe = (cnt_q == INH_LAST);
      S_REQ:     ps2_data_oe = 1'b1;
      S_DATA:    ps2_data_oe = ~byte_q[bit_q];
      S_PARITY:  ps2_data_oe = ~par_q;
      default:   ps2_data_oe = 1'b0;
    endcase
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign tx_active  = (state_q != S_IDLE);
  assign ps2_clk_oe = (state_q == S_INHIBIT);
  assign done       = done_q;
  assign ack_ok     = ack_ok_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Randomised bench for ps2_host_tx with a PS/2 device model on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
  localparam int IC = 600;
  localparam int TO = 2500;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_active, done, ack_ok, err;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (clk_line),
    .ps2_data_i  (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_active   (tx_active),
    .done        (done),
    .ack_ok      (ack_ok),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int exp_err_total = 0;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: how many attempts the host makes and whether it ends acknowledged.
  function automatic void model(input logic [2:0] nack, output int att, output bit ok);
    int max_att;
`ifdef PS2_HOST_TX_RETRY_EN
    max_att = 3;
`else
    max_att = 1;
`endif
    att = 0;
    ok  = 1'b0;
    for (int a = 0; a < max_att && !ok; a++) begin
      att++;
      ok = !nack[a];
    end
  endfunction

  function automatic logic [9:0] expected_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  task automatic offer(input logic [7:0] b);
    int i;
    i = 0;
    while (!tx_ready && i < 10 * TO) begin
      @(negedge clk);
      i++;
    end
    chk("ready_before_offer", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    chk("accept_clk_oe", ps2_clk_oe, 1);
    chk("accept_active", tx_active, 1);
    tx_valid = 1'($urandom_range(0, 1));
    tx_data  = 8'($urandom);
  endtask

  task automatic inhibit_phase(output int len, output int d_cnt, output logic d_last);
    len = 0; d_cnt = 0; d_last = 1'b0;
    while (ps2_clk_oe && len < IC + 100) begin
      d_last = ps2_data_oe;
      if (ps2_data_oe) d_cnt++;
      len++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic device_clock(input int half, input bit nack, input int pulses,
                              output logic [9:0] bits);
    bits = '0;
    for (int k = 1; k <= pulses; k++) begin
      if (k == 11 && !nack) dev_data_low = 1'b1;
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k-1] = data_line;
      if (k == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [2:0] nack_pat);
    int len, dc, att, exp_att, d0;
    logic dl;
    logic [9:0] bits;
    bit exp_ok, got_done, retried;
    model(nack_pat, exp_att, exp_ok);
    d0 = done_cnt;
    offer(b);
    att = 0;
    got_done = 1'b0;
    retried = 1'b1;
    while (!got_done && retried && att < 4) begin
      att++;
      retried = 1'b0;
      inhibit_phase(len, dc, dl);
      chk("inhibit_len", len, IC);
      chk("start_bit_timing", dc * 2 + int'(dl), 3);
      chk("req_data_oe", ps2_data_oe, 1);
      device_clock($urandom_range(12, 40), (att <= 3) ? nack_pat[att-1] : 1'b1, 11, bits);
      chk("frame_bits", bits, expected_frame(b));
      for (int i = 0; i < 4 * TO && !got_done && !retried; i++) begin
        @(negedge clk);
        if (done) begin
          got_done = 1'b1;
          chk("ack_ok", ack_ok, exp_ok);
          chk("err", err, !exp_ok);
        end else if (ps2_clk_oe) begin
          retried = 1'b1;
        end
      end
    end
    chk("done_seen", got_done, 1);
    chk("attempts", att, exp_att);
    if (!exp_ok) exp_err_total++;
    @(negedge clk);
    chk("done_width", done, 0);
    chk("ready_after_done", tx_ready, 1);
    chk("done_count", done_cnt - d0, 1);
  endtask

  task automatic timeout_test(input logic [7:0] b);
    int len, dc, half, d0;
    logic dl;
    logic [9:0] bits;
    d0 = done_cnt;
    offer(b);
    inhibit_phase(len, dc, dl);
    chk("tmo_inhibit_len", len, IC);
    half = $urandom_range(12, 40);
    device_clock(half, 1'b0, 4, bits);
    repeat (TO + 2 - half) @(negedge clk);
    chk("tmo_not_early", done, 0);
    @(negedge clk);
    chk("tmo_done", done, 1);
    chk("tmo_err", err, 1);
    chk("tmo_ack_ok", ack_ok, 0);
    chk("tmo_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    exp_err_total++;
    @(negedge clk);
    chk("tmo_ready", tx_ready, 1);
    chk("tmo_done_count", done_cnt - d0, 1);
  endtask

  task automatic reset_mid_data();
    int len, dc, d0;
    logic dl;
    logic [9:0] bits;
    offer(8'hA5);
    inhibit_phase(len, dc, dl);
    device_clock($urandom_range(12, 40), 1'b0, 3, bits);
    d0 = done_cnt;
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    @(negedge clk);
    chk("rst_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_active", tx_active, 0);
    rst = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", tx_active, 0);
    repeat (50) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", tx_ready, 1);
    chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("reset_status", {tx_active, done, ack_ok, err}, 0);
    rst = 1'b0;
    @(negedge clk);

    send(8'hED, 3'b000);
    send(8'hFF, 3'b000);
    send(8'h00, 3'b000);
    send(8'h01, 3'b000);
    send(8'h5A, 3'b111);
    send(8'hF4, 3'b011);
    for (int n = 0; n < 5; n++)
      send(8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
`ifndef PS2_HOST_TX_RETRY_EN
    timeout_test(8'hF4);
`endif
    reset_mid_data();
    send(8'hF4, 3'b000);
    @(negedge clk);
    chk("err_pulse_total", err_cnt, exp_err_total);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the opposite direction of the existing PS/2 keyboard receiver. It sends one command byte per request (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard over the shared open-drain PS2_CLK/PS2_DATA lines. It runs in the same 100 MHz domain as the receiver and game control logic. While a frame is in flight it asserts `tx_active`, and the receiver discards any bits it sees during that time.

## Interface
- `INHIBIT_CYCLES`, 12000: clocks the host holds PS2_CLK low before the start bit (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 2000000: maximum clocks allowed between device clock falling edges, and for the final bus-idle wait (20 ms).
- `clk` in 1: system clock (100 MHz).
- `rst` in 1: synchronous, active-high reset.
- `tx_valid` in 1: a command byte is offered.
- `tx_data` in 8: command byte.
- `tx_ready` out 1: high only in IDLE. A transfer is accepted on a cycle where `tx_valid && tx_ready`.
- `ps2_clk_i` in 1: raw PS2_CLK pin level.
- `ps2_data_i` in 1: raw PS2_DATA pin level.
- `ps2_clk_oe` out 1: 1 pulls PS2_CLK low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls PS2_DATA low; 0 releases it.
- `tx_active` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a frame ends (success or failure).
- `ack_ok` out 1: valid with `done`; 1 means the device acknowledged.
- `err` out 1: one-cycle pulse on NACK or timeout, coincident with `done`.

## Operation
- Input conditioning:
  - `ps2_clk_i` and `ps2_data_i` pass through 2-FF synchronisers.
  - A falling edge (`fe`) is the synchronised clock sampled 1 then 0 on consecutive cycles.
- On accept:
  - Latch `tx_data`.
  - Compute parity = ~^tx_data (odd parity).
  - Clear the bit counter.
- IDLE: both `oe` outputs are 0; `tx_ready`=1.
  - Accept → INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES clocks.
  - In the last of those cycles, set `ps2_data_oe`=1 (start bit) → REQ.
- REQ: `ps2_clk_oe`=0, `ps2_data_oe`=1.
  - On `fe` #1, drive bit0 (`ps2_data_oe` = ~bit) → DATA.
- DATA: on each `fe` #2..#8, drive bit1..bit7, LSB first.
  - On `fe` #9, drive parity → PARITY.
- PARITY: on `fe` #10, set `ps2_data_oe`=0 (stop bit) → ACK.
- ACK: on `fe` #11, sample synchronised data.
  - Data 0 records ack; data 1 records nack.
  - Then → WAIT_IDLE.
- WAIT_IDLE: wait until synchronised clock and data are both 1.
  - Then → DONE.
- DONE: one cycle.
  - Pulse `done`; `ack_ok` equals the recorded ack; `err` = ~ack.
  - Then → IDLE.
- Timeout:
  - In REQ/DATA/PARITY/ACK, a counter clears on every `fe` and on state entry. In WAIT_IDLE it clears only on entry.
  - Reaching TIMEOUT_CYCLES sets both `oe` to 0 → DONE with `ack_ok`=0, `err`=1.
- Boundaries:
  - `tx_valid` while busy is ignored; it is not queued.
  - `fe` in IDLE or INHIBIT is ignored.
  - Reset in any state: next cycle is IDLE with both lines released. A partial frame is abandoned with no `done`.
  - Reset wins over a simultaneous accept.

## Timing
- Reset values:
  - `tx_ready`=1.
  - `ps2_clk_oe`, `ps2_data_oe`, `tx_active`, `done`, `ack_ok`, `err` = 0.
- Accept at cycle N: `ps2_clk_oe`=1 and `tx_active`=1 from cycle N+1.
- `ps2_data_oe` rises at cycle N+INHIBIT_CYCLES.
- `ps2_clk_oe` falls at cycle N+INHIBIT_CYCLES+1.
- Pin falling edge to `oe` update: 3 clocks (2 sync + edge register). This is well inside the device's ≥30 µs clock-low phase.
- `done`/`err` are registered: asserted the cycle after the DONE decision, for exactly one cycle. `tx_ready` returns the following cycle.

## Configuration
- `PS2_HOST_TX_RETRY_EN` defined:
  - On NACK or timeout, the block automatically restarts from INHIBIT with the same byte, up to 2 retries.
  - `done`/`err` pulse only after the final attempt.
  - `tx_active` stays high across retries.
- Not defined: the first NACK or timeout ends the transfer with `err`.

## Test plan
- Accept 0xED with a device model clocking at 12.5 kHz and ACKing:
  - Expect `ps2_clk_oe` high for exactly 12000 cycles.
  - Expect data bits 1,0,1,1,0,1,1,1 then parity 1 and stop.
  - Expect `done`=1, `ack_ok`=1, `err`=0.
- Send 0xFF (parity 1) and 0x00 (parity 1); send 0x01 (parity 0):
  - The parity bit seen by the device model matches in each case.
- Device leaves data high on `fe` #11:
  - Expect `done`=1, `ack_ok`=0, `err`=1.
  - Without the macro, `tx_ready` returns with no retry.
- Device stops clocking after `fe` #4:
  - Exactly TIMEOUT_CYCLES later, both `oe`=0 and `err`=1.
- Assert `rst` mid-DATA:
  - Next cycle both `oe`=0, `tx_ready`=1, `tx_active`=0, no `done`.
  - `tx_valid` pulsed in the same cycle as `rst` is not accepted.
- With `PS2_HOST_TX_RETRY_EN`, device NACKs twice then ACKs:
  - Expect 3 INHIBIT phases and a single `done` with `ack_ok`=1.
  - With NACK on all three attempts: a single `err`.
